// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter that grants one processing element at a time a burst
// of consecutive-address beats on a single shared memory port.
module shared_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    i_len,
  input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [LEN_W-1:0]            o_beat,
  output logic [NUM_REQ-1:0]          o_done,
  output logic [NUM_REQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_mem_en,
  output logic                        o_mem_we,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  input  logic [DATA_W-1:0]           i_mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_r, state_nx_s;
  logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nx_s;
  logic [IDX_W-1:0]     win_r, win_nx_s;
  logic                 we_r, we_nx_s;
  logic [LEN_W-1:0]     len_r, len_nx_s;
  logic [LEN_W-1:0]     beat_r, beat_nx_s;
  logic [NUM_REQ-1:0]   gnt_r, gnt_nx_s;
  logic [NUM_REQ-1:0]   done_r, done_nx_s;
  logic [NUM_REQ-1:0]   rvalid_r, rvalid_nx_s;
  logic                 mem_en_r, mem_en_nx_s;
  logic                 mem_we_r, mem_we_nx_s;
  logic [ADDR_W-1:0]    mem_addr_r, mem_addr_nx_s;
  logic [IDX_W-1:0]     sel_s;
  logic                 any_req_s;
  logic [LEN_W-1:0]     sel_len_s;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (IDX_W'(i) == idx);
    end
    return v;
  endfunction

  assign any_req_s = |i_req;
  assign sel_len_s = i_len[sel_s*LEN_W +: LEN_W];

  // Round-robin search from rr_ptr upward, wrapping modulo NUM_REQ
  always_comb begin
    logic found_v;
    int   k_v;
    found_v = 1'b0;
    sel_s   = rr_ptr_r;
    k_v     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k_v = int'(rr_ptr_r) + i;
      k_v = (k_v >= NUM_REQ) ? (k_v - NUM_REQ) : k_v;
      if (!found_v && i_req[k_v]) begin
        sel_s   = IDX_W'(k_v);
        found_v = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) state_nx_s = ST_BURST;
        else           state_nx_s = ST_IDLE;
      end
      ST_BURST: begin
        if (beat_r == len_r) state_nx_s = ST_IDLE;
        else                 state_nx_s = ST_BURST;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Next values of the burst context and of every registered output
  always_comb begin
    rr_ptr_nx_s   = rr_ptr_r;
    win_nx_s      = win_r;
    we_nx_s       = we_r;
    len_nx_s      = len_r;
    beat_nx_s     = {LEN_W{1'b0}};
    gnt_nx_s      = {NUM_REQ{1'b0}};
    done_nx_s     = {NUM_REQ{1'b0}};
    mem_en_nx_s   = 1'b0;
    mem_we_nx_s   = 1'b0;
    mem_addr_nx_s = {ADDR_W{1'b0}};
    // A read beat issued this cycle returns its data one cycle later
    rvalid_nx_s   = (mem_en_r && !mem_we_r) ? gnt_r : {NUM_REQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          win_nx_s      = sel_s;
          we_nx_s       = i_we[sel_s];
          len_nx_s      = sel_len_s;
          gnt_nx_s      = idx_onehot(sel_s);
          mem_en_nx_s   = 1'b1;
          mem_we_nx_s   = i_we[sel_s];
          mem_addr_nx_s = i_addr[sel_s*ADDR_W +: ADDR_W];
          done_nx_s     = (sel_len_s == {LEN_W{1'b0}}) ? idx_onehot(sel_s) : {NUM_REQ{1'b0}};
        end else begin
          win_nx_s = win_r;
        end
      end
      ST_BURST: begin
        if (beat_r == len_r) begin
          rr_ptr_nx_s = (win_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (win_r + IDX_W'(1'b1));
        end else begin
          gnt_nx_s      = gnt_r;
          beat_nx_s     = beat_r + LEN_W'(1'b1);
          mem_en_nx_s   = 1'b1;
          mem_we_nx_s   = we_r;
          mem_addr_nx_s = mem_addr_r + ADDR_W'(1'b1);
          done_nx_s     = ((beat_r + LEN_W'(1'b1)) == len_r) ? gnt_r : {NUM_REQ{1'b0}};
        end
      end
      default: begin
        rr_ptr_nx_s = rr_ptr_r;
      end
    endcase
  end

  // Burst context and output registers; reset aborts any burst in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_r   <= {IDX_W{1'b0}};
      win_r      <= {IDX_W{1'b0}};
      we_r       <= 1'b0;
      len_r      <= {LEN_W{1'b0}};
      beat_r     <= {LEN_W{1'b0}};
      gnt_r      <= {NUM_REQ{1'b0}};
      done_r     <= {NUM_REQ{1'b0}};
      rvalid_r   <= {NUM_REQ{1'b0}};
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
    end else begin
      rr_ptr_r   <= rr_ptr_nx_s;
      win_r      <= win_nx_s;
      we_r       <= we_nx_s;
      len_r      <= len_nx_s;
      beat_r     <= beat_nx_s;
      gnt_r      <= gnt_nx_s;
      done_r     <= done_nx_s;
      rvalid_r   <= rvalid_nx_s;
      mem_en_r   <= mem_en_nx_s;
      mem_we_r   <= mem_we_nx_s;
      mem_addr_r <= mem_addr_nx_s;
    end
  end

  assign o_gnt       = gnt_r;
  assign o_beat      = beat_r;
  assign o_done      = done_r;
  assign o_rvalid    = rvalid_r;
  assign o_mem_en    = mem_en_r;
  assign o_mem_we    = mem_we_r;
  assign o_mem_addr  = mem_addr_r;
  // Write data is steered straight from the granted requester's current-beat slice
  assign o_mem_wdata = mem_en_r ? i_wdata[win_r*DATA_W +: DATA_W] : {DATA_W{1'b0}};
  assign o_rdata     = (|rvalid_r) ? i_mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed self-checking bench for shared_mem_arbiter with a one-cycle-latency
// memory model returning {16'hA5A5, address} for reads.
module tb_shared_mem_arbiter;

  logic          i_clk;
  logic          i_rst;
  logic [3:0]    i_req;
  logic [3:0]    i_we;
  logic [63:0]   i_addr;
  logic [11:0]   i_len;
  logic [127:0]  i_wdata;
  logic [3:0]    o_gnt;
  logic [2:0]    o_beat;
  logic [3:0]    o_done;
  logic [3:0]    o_rvalid;
  logic [31:0]   o_rdata;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [15:0]   o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  int checks;
  int failures;

  shared_mem_arbiter dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_len       (i_len),
    .i_wdata     (i_wdata),
    .o_gnt       (o_gnt),
    .o_beat      (o_beat),
    .o_done      (o_done),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory model: read data appears exactly one cycle after a read strobe
  always @(posedge i_clk) begin
    i_mem_rdata <= (o_mem_en && !o_mem_we) ? {16'hA5A5, o_mem_addr} : 32'h0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic we, input logic [15:0] addr, input logic [2:0] len);
    i_we[r]           = we;
    i_addr[r*16 +: 16] = addr;
    i_len[r*3 +: 3]    = len;
  endtask

  task automatic chk_quiet(input string tag);
    check_eq({tag, "_gnt"},    {28'h0, o_gnt},    32'h0);
    check_eq({tag, "_done"},   {28'h0, o_done},   32'h0);
    check_eq({tag, "_mem_en"}, {31'h0, o_mem_en}, 32'h0);
  endtask

  initial begin
    logic [15:0] ea;
    logic [3:0]  eg;
    checks      = 0;
    failures    = 0;
    i_rst       = 1'b1;
    i_req       = 4'h0;
    i_we        = 4'h0;
    i_addr      = 64'h0;
    i_len       = 12'h0;
    i_wdata     = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    i_mem_rdata = 32'h0;
    step();
    step();
    i_rst = 1'b0;

    // Reset state
    chk_quiet("rst");
    check_eq("rst_rvalid", {28'h0, o_rvalid},  32'h0);
    check_eq("rst_beat",   {29'h0, o_beat},    32'h0);
    check_eq("rst_addr",   {16'h0, o_mem_addr}, 32'h0);
    check_eq("rst_we",     {31'h0, o_mem_we},  32'h0);
    check_eq("rst_rdata",  o_rdata,            32'h0);
    check_eq("rst_wdata",  o_mem_wdata,        32'h0);

    // Single 4-beat read from requester 0
    set_req(0, 1'b0, 16'h0010, 3'd3);
    i_req = 4'b0001;
    step();
    i_req = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      check_eq("rd_gnt",    {28'h0, o_gnt},     32'h1);
      check_eq("rd_en",     {31'h0, o_mem_en},  32'h1);
      check_eq("rd_we",     {31'h0, o_mem_we},  32'h0);
      check_eq("rd_addr",   {16'h0, o_mem_addr}, 32'h10 + b);
      check_eq("rd_beat",   {29'h0, o_beat},    b);
      check_eq("rd_done",   {28'h0, o_done},    (b == 3) ? 32'h1 : 32'h0);
      check_eq("rd_rvalid", {28'h0, o_rvalid},  (b == 0) ? 32'h0 : 32'h1);
      check_eq("rd_rdata",  o_rdata,            (b == 0) ? 32'h0 : (32'hA5A5_0010 + b - 1));
      step();
    end
    chk_quiet("rd_tail");
    check_eq("rd_tail_rvalid", {28'h0, o_rvalid}, 32'h1);
    check_eq("rd_tail_rdata",  o_rdata,           32'hA5A5_0013);
    step();
    check_eq("rd_end_rvalid",  {28'h0, o_rvalid}, 32'h0);

    // Contention: all requesters, one-beat writes, reset wins over a pending request
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 16'h0100 + 16'(r), 3'd0);
    i_rst = 1'b1;
    i_req = 4'b1111;
    step();
    chk_quiet("rst_prio");
    i_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      eg = 4'b0001 << (k % 4);
      check_eq("rr_gnt",  {28'h0, o_gnt},  {28'h0, eg});
      check_eq("rr_done", {28'h0, o_done}, {28'h0, eg});
      check_eq("rr_rvalid", {28'h0, o_rvalid}, 32'h0);
      if (k == 4) i_req = 4'b0000;
      step();
      chk_quiet("rr_gap");
    end

    // Address wrap on a write burst from requester 3
    set_req(3, 1'b1, 16'hFFFE, 3'd3);
    i_req = 4'b1000;
    step();
    i_req = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      i_wdata[96 +: 32] = 32'hC0DE_0000 + b;
      #1;
      ea = 16'hFFFE + 16'(b);
      check_eq("wr_addr",   {16'h0, o_mem_addr}, {16'h0, ea});
      check_eq("wr_we",     {31'h0, o_mem_we},   32'h1);
      check_eq("wr_gnt",    {28'h0, o_gnt},      32'h8);
      check_eq("wr_wdata",  o_mem_wdata,         32'hC0DE_0000 + b);
      check_eq("wr_rvalid", {28'h0, o_rvalid},   32'h0);
      check_eq("wr_done",   {28'h0, o_done},     (b == 3) ? 32'h8 : 32'h0);
      step();
    end
    chk_quiet("wr_tail");
    check_eq("wr_tail_rvalid", {28'h0, o_rvalid}, 32'h0);

    // Requester 2 drops request and changes its fields mid-burst
    set_req(2, 1'b0, 16'h0200, 3'd7);
    i_req = 4'b0100;
    step();
    for (int b = 0; b < 8; b++) begin
      check_eq("mid_gnt",  {28'h0, o_gnt},      32'h4);
      check_eq("mid_addr", {16'h0, o_mem_addr}, 32'h200 + b);
      check_eq("mid_we",   {31'h0, o_mem_we},   32'h0);
      check_eq("mid_done", {28'h0, o_done},     (b == 7) ? 32'h4 : 32'h0);
      if (b == 1) begin
        i_req = 4'b0000;
        set_req(2, 1'b1, 16'h0999, 3'd1);
      end
      step();
    end
    chk_quiet("mid_tail");
    check_eq("mid_tail_rvalid", {28'h0, o_rvalid}, 32'h4);
    check_eq("mid_tail_rdata",  o_rdata,           32'hA5A5_0207);
    step();

    // Reset during beat 2 of a read burst from requester 1
    set_req(1, 1'b0, 16'h0040, 3'd3);
    i_req = 4'b0010;
    step();
    i_req = 4'b0000;
    step();
    step();
    check_eq("abort_beat", {29'h0, o_beat},     32'h2);
    check_eq("abort_addr", {16'h0, o_mem_addr}, 32'h42);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk_quiet("abort");
    check_eq("abort_rvalid", {28'h0, o_rvalid},  32'h0);
    check_eq("abort_rdata",  o_rdata,            32'h0);
    check_eq("abort_beat0",  {29'h0, o_beat},    32'h0);
    check_eq("abort_addr0",  {16'h0, o_mem_addr}, 32'h0);

    // Pointer restarts at 0: requesters 1 and 3 both ask, 1 must win
    set_req(1, 1'b0, 16'h0050, 3'd0);
    set_req(3, 1'b0, 16'h0070, 3'd0);
    set_req(0, 1'b0, 16'h0030, 3'd0);
    i_req = 4'b1010;
    step();
    check_eq("ptr_gnt",  {28'h0, o_gnt},      32'h2);
    check_eq("ptr_addr", {16'h0, o_mem_addr}, 32'h50);
    check_eq("ptr_done", {28'h0, o_done},     32'h2);

    // Fairness: after requester 1, requester 0 wins before 1 again
    i_req = 4'b0011;
    step();
    chk_quiet("fair_gap0");
    check_eq("fair_rvalid", {28'h0, o_rvalid}, 32'h2);
    step();
    check_eq("fair_gnt0", {28'h0, o_gnt}, 32'h1);
    step();
    chk_quiet("fair_gap1");
    step();
    check_eq("fair_gnt1", {28'h0, o_gnt}, 32'h2);
    i_req = 4'b0000;
    step();
    chk_quiet("fair_end");
    step();
    chk_quiet("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting processing elements.
REQ-002 Parameter ADDR_W, default 16, shared-memory word address width.
REQ-003 Parameter DATA_W, default 32, memory word width.
REQ-004 Parameter LEN_W, default 3, burst-length field width; bursts are 1..2**LEN_W beats.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 i_clk  in  1  rising-edge clock.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_req  in  NUM_REQ  per-requester burst request, level.
REQ-009 i_we  in  NUM_REQ  per-requester write (1) / read (0).
REQ-010 i_addr  in  NUM_REQ*ADDR_W  per-requester burst base address.
REQ-011 i_len  in  NUM_REQ*LEN_W  per-requester burst length minus one.
REQ-012 i_wdata  in  NUM_REQ*DATA_W  per-requester write data for the current beat.
REQ-013 o_gnt  out  NUM_REQ  one-hot grant, high for the whole burst.
REQ-014 o_beat  out  LEN_W  index of the beat issued this cycle.
REQ-015 o_done  out  NUM_REQ  one-cycle pulse on the last beat of a burst.
REQ-016 o_rvalid  out  NUM_REQ  read data valid, per requester.
REQ-017 o_rdata  out  DATA_W  read data, shared by all requesters.
REQ-018 o_mem_en, o_mem_we  out  1 each  memory access strobe and write enable.
REQ-019 o_mem_addr  out  ADDR_W; o_mem_wdata  out  DATA_W  memory address and write data.
REQ-020 i_mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-021 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-022 In IDLE with any i_req set, the block SHALL select a winner round-robin, starting at pointer rr_ptr and searching upward with wrap modulo NUM_REQ.
REQ-023 On selection, the block SHALL latch the winner's index, i_we, i_addr and i_len, SHALL set o_gnt[winner] and o_beat=0, and SHALL enter BURST on the next cycle.
REQ-024 In IDLE, o_mem_en, o_gnt and o_done SHALL be 0.
REQ-025 In BURST, each cycle SHALL issue exactly one beat with o_mem_en=1, o_mem_we equal to the latched we, and o_mem_addr = latched base + o_beat (modulo 2**ADDR_W, wrapping).
REQ-026 In BURST, o_mem_wdata SHALL equal the granted requester's i_wdata slice combinationally; the requester indexes its data by o_beat.
REQ-027 o_beat SHALL increment by one per BURST cycle.
REQ-028 On the cycle o_beat equals the latched length, o_done[winner] SHALL pulse, and the next state SHALL be IDLE with rr_ptr = (winner+1) mod NUM_REQ.
REQ-029 o_gnt SHALL clear on the cycle after the last beat, so a back-to-back grant always has one IDLE cycle between bursts.
REQ-030 Deassertion of i_req, or changes to i_addr, i_len or i_we, during BURST SHALL be ignored; the burst always completes.
REQ-031 For read beats, o_rvalid[winner] SHALL be high one cycle after the beat, with o_rdata = i_mem_rdata; this holds even when that cycle is in IDLE.
REQ-032 Write beats SHALL never assert o_rvalid.
REQ-033 Burst length 0 (one beat) SHALL assert o_done on the first BURST cycle.
REQ-034 o_gnt and o_rvalid SHALL always be one-hot or zero.

Reset
REQ-035 After i_rst, all outputs SHALL be 0, the FSM SHALL be in IDLE, and rr_ptr SHALL be 0.
REQ-036 Reset during BURST SHALL abort the burst immediately, with no o_done pulse and any pending o_rvalid suppressed.
REQ-037 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-038 Single read: i_req=0001, addr=0x0010, len=3, reads -> gnt=0001 for 4 cycles, mem_addr 0x10..0x13, o_done[0] on the 4th beat, rvalid[0] on 4 cycles each lagging one cycle.
REQ-039 Contention: i_req=1111 held, len=0, starting after reset -> grants in order 0,1,2,3,0, each a one-beat burst separated by one IDLE cycle.
REQ-040 Address wrap: addr=0xFFFE, len=3, write -> mem_addr FFFE, FFFF, 0000, 0001 with mem_we=1 and no rvalid.
REQ-041 Mid-burst change: requester 2 drops i_req and changes i_addr after beat 1 of a len=7 burst -> all 8 beats complete at the original addresses.
REQ-042 Reset mid-burst: assert i_rst at beat 2 of a read burst -> next cycle all outputs are 0, no o_done or rvalid, and the next arbitration starts from requester 0.
REQ-043 Pointer fairness: requester 1 wins, then i_req=0011 -> requester 0 wins before requester 1 is granted again.
